// File: rtl/fpu_result_collector.sv
// ---------------------------------------------------------------------------
// fpu_result_collector
//
// Sits directly downstream of a fixed-latency FPU.
// - Tracks every op issued into the FPU pipe with a {valid, rd} tag pipe.
// - Captures the FPU result and flags when the tag reaches the last stage.
// - Buffers that result in a small circular FIFO.
// - Presents the FIFO head to register-file writeback over valid/ready.
// - Accumulates the exception flags of retired ops into a sticky fflags
//   register, which a CSR can also write.
//
// Issue is credit-throttled: an op is accepted only if every op already in
// flight, plus the new one, is guaranteed a FIFO slot.
//
// Parameters
//   LATENCY  cycles from operands applied to the FPU until its outputs are valid
//   DEPTH    result FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid/issue_ready  issue handshake toward the FPU front end
//   issue_rd                 destination tag of the issued op
//   fpu_result, fpu_flags    FPU outputs {NV,DZ,OF,UF,NX}
//   out_valid/out_ready      writeback handshake
//   out_data/out_rd/out_flags  FIFO head contents (zero while empty)
//   fflags                   sticky accumulated exception flags
//   fflags_wr, fflags_wdata  CSR write of fflags
// ---------------------------------------------------------------------------
module fpu_result_collector #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_wr,
  input  logic [4:0]  fflags_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Wide enough for a full FIFO plus a full tag pipe.
  localparam int OCC_W = $clog2(DEPTH + LATENCY + 1);

  // Tag pipe state.
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [4:0]         tag_rd_q [LATENCY];
  logic [4:0]         tag_rd_d [LATENCY];

  // FIFO storage and control.
  logic [31:0]      mem_data_q  [DEPTH];
  logic [31:0]      mem_data_d  [DEPTH];
  logic [4:0]       mem_rd_q    [DEPTH];
  logic [4:0]       mem_rd_d    [DEPTH];
  logic [4:0]       mem_flags_q [DEPTH];
  logic [4:0]       mem_flags_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;

  logic             fire;
  logic             push;
  logic             pop;
  logic             full;
  logic [OCC_W-1:0] inflight;
  logic [OCC_W-1:0] occupancy;

  // Explicit wrap so a non-power-of-two DEPTH still behaves as a ring.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = ptr + PTR_W'(1);
    end
  endfunction

  // Credit check uses registered state only, so issue_ready never depends
  // combinationally on issue_valid or on the writeback side.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + OCC_W'(tag_vld_q[i]);
    end
    occupancy   = OCC_W'(count_q) + inflight;
    issue_ready = occupancy < OCC_W'(DEPTH);
    fire        = issue_valid && issue_ready;
    push        = tag_vld_q[LATENCY-1];
    full        = (count_q == CNT_W'(DEPTH));
    out_valid   = (count_q != '0);
    pop         = out_valid && out_ready;
  end

  // Head is shown combinationally; outputs read as zero while empty.
  always_comb begin
    out_data  = '0;
    out_rd    = '0;
    out_flags = '0;
    if (out_valid) begin
      out_data  = mem_data_q[rd_ptr_q];
      out_rd    = mem_rd_q[rd_ptr_q];
      out_flags = mem_flags_q[rd_ptr_q];
    end
  end

  assign fflags = fflags_q;

  // Stage boundary: issue -> tag pipe (stage 0 loads this cycle's issue).
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = fire;
    tag_rd_d[0]  = issue_rd;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_rd_d[i]  = tag_rd_q[i-1];
    end
  end

  // Stage boundary: tag pipe last stage -> FIFO write.
  always_comb begin
    mem_data_d  = mem_data_q;
    mem_rd_d    = mem_rd_q;
    mem_flags_d = mem_flags_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (push) begin
      mem_data_d[wr_ptr_q]  = fpu_result;
      mem_rd_d[wr_ptr_q]    = tag_rd_q[LATENCY-1];
      mem_flags_d[wr_ptr_q] = fpu_flags;
      wr_ptr_d              = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are accumulated at retirement; a popped op's flags survive a
  // same-cycle CSR write.
  always_comb begin
    fflags_d = (fflags_wr ? fflags_wdata : fflags_q) | (pop ? out_flags : 5'b0);
  end

  // Control state: cleared by reset so in-flight ops are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fflags_q  <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fflags_q  <= fflags_d;
    end
  end

  // Data state: only meaningful under a valid tag or a live FIFO entry.
  always_ff @(posedge clk) begin
    tag_rd_q    <= tag_rd_d;
    mem_data_q  <= mem_data_d;
    mem_rd_q    <= mem_rd_d;
    mem_flags_q <= mem_flags_d;
  end

  // Credits make this unreachable; firing means the throttle is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full));
    end
  end

endmodule

// File: tb/tb_fpu_result_collector.sv
module tb_fpu_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_wr;
  logic [4:0]  fflags_wdata;

  // Values the bench "applies as operands" this cycle; the FPU model below
  // presents them two cycles later, like a 2-cycle FPU.
  logic [31:0] op_res, m_res1, m_res2;
  logic [4:0]  op_flg, m_flg1, m_flg2;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_res [$];
  logic [4:0]  q_rd  [$];
  logic [4:0]  q_flg [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_res1 <= op_res;
    m_res2 <= m_res1;
    m_flg1 <= op_flg;
    m_flg2 <= m_flg1;
  end

  assign fpu_result = m_res2;
  assign fpu_flags  = m_flg2;

  fpu_result_collector #(.LATENCY(2), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rd     (issue_rd),
    .fpu_result   (fpu_result),
    .fpu_flags    (fpu_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_flags    (out_flags),
    .fflags       (fflags),
    .fflags_wr    (fflags_wr),
    .fflags_wdata (fflags_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboarded traffic: issue_valid/out_ready either always high or random.
  task automatic run_traffic(input int n_ops, input bit rand_mode, input string tag);
    int          issued;
    int          retired;
    int          cyc;
    logic [4:0]  ff_model;
    logic [31:0] a, b;
    issued   = 0;
    retired  = 0;
    cyc      = 0;
    ff_model = 5'b0;
    while (retired < n_ops && cyc < 20 * n_ops + 100) begin
      check({tag, " fflags"}, 32'(fflags), 32'(ff_model));
      out_ready   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      issue_valid = (issued < n_ops) && (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
      issue_rd    = 5'($urandom);
      a           = 32'($urandom_range(1, 65535));
      b           = 32'($urandom_range(1, 65535));
      op_res      = a * b;
      op_flg      = 5'($urandom);
      if (issue_valid && issue_ready) begin
        q_res.push_back(op_res);
        q_rd.push_back(issue_rd);
        q_flg.push_back(op_flg);
        issued++;
      end
      if (out_valid) begin
        check({tag, " head expected"}, 32'(q_res.size() != 0), 32'd1);
        if (q_res.size() != 0) begin
          check({tag, " out_data"},  out_data,         q_res[0]);
          check({tag, " out_rd"},    32'(out_rd),      32'(q_rd[0]));
          check({tag, " out_flags"}, 32'(out_flags),   32'(q_flg[0]));
          if (out_ready) begin
            ff_model = ff_model | q_flg[0];
            void'(q_res.pop_front());
            void'(q_rd.pop_front());
            void'(q_flg.pop_front());
            retired++;
          end
        end
      end
      tick();
      cyc++;
    end
    issue_valid = 1'b0;
    out_ready   = 1'b1;
    check({tag, " all retired"}, 32'(retired), 32'(n_ops));
    tick();
    tick();
    tick();
    tick();
    check({tag, " drained out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " drained issue_ready"}, 32'(issue_ready), 32'd1);
    check({tag, " final fflags"}, 32'(fflags), 32'(ff_model));
    check({tag, " scoreboard empty"}, 32'(q_res.size()), 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    issue_valid  = 1'b0;
    issue_rd     = 5'd0;
    op_res       = 32'd0;
    op_flg       = 5'd0;
    out_ready    = 1'b0;
    fflags_wr    = 1'b0;
    fflags_wdata = 5'd0;

    // Reset and idle
    #2 rst = 1'b1;
    tick();
    tick();
    check("rst issue_ready", 32'(issue_ready), 32'd1);
    check("rst out_valid",   32'(out_valid),   32'd0);
    check("rst out_data",    out_data,         32'd0);
    check("rst out_rd",      32'(out_rd),      32'd0);
    check("rst out_flags",   32'(out_flags),   32'd0);
    check("rst fflags",      32'(fflags),      32'd0);
    rst = 1'b0;
    tick();
    check("idle issue_ready", 32'(issue_ready), 32'd1);
    check("idle out_valid",   32'(out_valid),   32'd0);

    // Single multiply: 2.0*3.0 = 6.0, rd=7, out_valid on cycle 3
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    op_res      = 32'h40C00000;
    op_flg      = 5'b0;
    check("single ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    check("single c1 out_valid", 32'(out_valid), 32'd0);
    tick();
    check("single c2 out_valid", 32'(out_valid), 32'd0);
    tick();
    check("single c3 out_valid", 32'(out_valid), 32'd1);
    check("single out_data",     out_data,       32'h40C00000);
    check("single out_rd",       32'(out_rd),    32'd7);
    check("single out_flags",    32'(out_flags), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single popped",      32'(out_valid),   32'd0);
    check("single fflags",      32'(fflags),      32'd0);
    check("single issue_ready", 32'(issue_ready), 32'd1);

    // Reset while an op is in flight: nothing may ever appear
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    op_res      = 32'h11111111;
    op_flg      = 5'b10000;
    tick();
    issue_valid = 1'b0;
    out_ready   = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrst issue_ready", 32'(issue_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("midrst out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    check("midrst fflags", 32'(fflags), 32'd0);
    out_ready = 1'b0;

    // Back-to-back issues with out_ready low, then drain
    issue_valid = 1'b1;
    issue_rd    = 5'd1;
    op_res      = 32'h3F800000;
    op_flg      = 5'b00001;
    check("b2b c0 ready", 32'(issue_ready), 32'd1);
    tick();
    issue_rd = 5'd2;
    op_res   = 32'h40000000;
    op_flg   = 5'b00100;
    check("b2b c1 ready", 32'(issue_ready), 32'd1);
    tick();
    issue_rd = 5'd3;
    op_res   = 32'h40400000;
    op_flg   = 5'b00000;
    check("b2b c2 ready low", 32'(issue_ready), 32'd0);
    tick();
    issue_valid = 1'b0;
    check("b2b c3 out_valid", 32'(out_valid),   32'd1);
    check("b2b c3 out_rd",    32'(out_rd),      32'd1);
    check("b2b c3 out_data",  out_data,         32'h3F800000);
    check("b2b c3 ready",     32'(issue_ready), 32'd0);
    tick();
    check("b2b hold out_data",  out_data,         32'h3F800000);
    check("b2b hold out_rd",    32'(out_rd),      32'd1);
    check("b2b hold out_flags", 32'(out_flags),   32'd1);
    check("b2b full ready",     32'(issue_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check("b2b 2nd out_valid", 32'(out_valid),   32'd1);
    check("b2b 2nd out_rd",    32'(out_rd),      32'd2);
    check("b2b 2nd out_data",  out_data,         32'h40000000);
    check("b2b fflags NX",     32'(fflags),      32'd1);
    check("b2b ready back",    32'(issue_ready), 32'd1);
    tick();
    check("b2b empty",        32'(out_valid),   32'd0);
    check("b2b fflags NX|OF", 32'(fflags),      32'h05);
    check("b2b ready idle",   32'(issue_ready), 32'd1);
    tick();
    tick();
    check("b2b ignored op absent", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // CSR write of zero in the same cycle as a pop carrying NV
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    op_res      = 32'hDEADBEEF;
    op_flg      = 5'b10000;
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    check("csr head valid", 32'(out_valid), 32'd1);
    check("csr head flags", 32'(out_flags), 32'h10);
    fflags_wr    = 1'b1;
    fflags_wdata = 5'b00000;
    out_ready    = 1'b1;
    tick();
    check("csr write+pop fflags", 32'(fflags),    32'h10);
    check("csr popped",           32'(out_valid), 32'd0);
    out_ready    = 1'b0;
    fflags_wdata = 5'b00011;
    tick();
    check("csr write only", 32'(fflags), 32'h03);
    fflags_wdata = 5'b00000;
    tick();
    fflags_wr = 1'b0;
    check("csr clear", 32'(fflags), 32'd0);

    // Steady stream then random backpressure, both scoreboarded
    run_traffic(12, 1'b0, "stream");
    fflags_wr    = 1'b1;
    fflags_wdata = 5'b0;
    tick();
    fflags_wr = 1'b0;
    run_traffic(1500, 1'b1, "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
